// File: rtl/tri_wave_analyzer_pkg.sv
// ---------------------------------------------------------------------------
// tri_wave_pkg
// Shared definitions for the triangle-wave analyzer slice: the slope-tracking
// FSM state encoding and the default sample / period widths.
// Optional feature macro used by this slice: TRI_WAVE_ANALYZER_STEP_CHECK_EN
// ---------------------------------------------------------------------------
package tri_wave_pkg;

    // Slope tracker states: IDLE waits for the first sample, ACQ waits for the
    // first non-equal sample to learn a direction, RISE/FALL track the slope.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        RISE = 2'd2,
        FALL = 2'd3
    } tri_state_t;

    localparam int DATA_W_DEF = 8;
    localparam int PER_W_DEF  = 16;

endpackage : tri_wave_pkg

// File: rtl/tri_wave_analyzer_if.sv
// ---------------------------------------------------------------------------
// tri_wave_analyzer_if
// Sample stream into the analyzer.
//   sample_in     DATA_W  incoming sample
//   sample_valid  1       sample_in is valid this cycle
// Modports: master (stream producer), slave (analyzer).
// ---------------------------------------------------------------------------
interface tri_wave_analyzer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;

    modport master (output sample_in, output sample_valid);
    modport slave  (input  sample_in, input  sample_valid);
endinterface : tri_wave_analyzer_if

// File: rtl/tri_wave_analyzer_period_meter.sv
// ---------------------------------------------------------------------------
// tri_period_meter
// Counts valid samples between successive peak events, publishes the count as
// the period, and flags lock when two consecutive periods are equal.
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   sample_valid in   a sample was consumed this cycle
//   peak_event   in   strobe from the slope FSM, only with sample_valid
//   period       out  PER_W  samples between the last two peaks (saturating)
//   meas_valid   out  one-cycle pulse when period is updated
//   locked       out  last two periods were equal
// ---------------------------------------------------------------------------
module tri_period_meter #(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sample_valid,
    input  logic             peak_event,
    output logic [PER_W-1:0] period,
    output logic             meas_valid,
    output logic             locked
);

    localparam logic [PER_W-1:0] CNT_MAX = '1;
    localparam logic [PER_W-1:0] CNT_ONE = PER_W'(1);

    logic [PER_W-1:0] cnt;
    logic             have_peak;

    // The sample that reveals a peak is the first sample of the new period,
    // so the counter restarts at 1. The very first peak only arms the meter
    // because there is no earlier peak to measure from. The counter holds at
    // its maximum instead of wrapping so a stalled waveform reads as "long".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            have_peak  <= 1'b0;
            period     <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (sample_valid) begin
                if (peak_event) begin
                    cnt       <= CNT_ONE;
                    have_peak <= 1'b1;
                    if (have_peak) begin
                        period     <= cnt;
                        meas_valid <= 1'b1;
                        locked     <= (cnt == period);
                    end
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end

endmodule : tri_period_meter

// File: rtl/tri_wave_analyzer.sv
// ---------------------------------------------------------------------------
// tri_wave_analyzer
// Measurement end of the triangle-wave stream: tracks slope direction,
// captures peak/trough values and amplitude, and measures the peak-to-peak
// period through tri_period_meter.
// Optional feature: define TRI_WAVE_ANALYZER_STEP_CHECK_EN to build a sticky
// detector for sample steps larger than MAX_STEP; otherwise step_err is 0.
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   smp         slave modport of tri_wave_analyzer_if (sample_in/sample_valid)
//   peak_val    out  DATA_W  last captured peak
//   trough_val  out  DATA_W  last captured trough
//   amplitude   out  DATA_W  peak_val - trough_val, 0 if trough is above peak
//   period      out  PER_W   valid samples between the last two peaks
//   meas_valid  out  one-cycle pulse when period updates
//   rising      out  slope FSM is in RISE
//   locked      out  two consecutive equal periods seen
//   step_err    out  sticky step-size violation
// ---------------------------------------------------------------------------
module tri_wave_analyzer
    import tri_wave_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int PER_W    = PER_W_DEF,
    parameter int MAX_STEP = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tri_wave_analyzer_if.slave   smp,
    output logic [DATA_W-1:0]    peak_val,
    output logic [DATA_W-1:0]    trough_val,
    output logic [DATA_W-1:0]    amplitude,
    output logic [PER_W-1:0]     period,
    output logic                 meas_valid,
    output logic                 rising,
    output logic                 locked,
    output logic                 step_err
);

    tri_state_t        state, state_next;
    logic [DATA_W-1:0] prev;
    logic              gt, lt;
    logic              peak_event, trough_event;

    assign gt     = (smp.sample_in > prev);
    assign lt     = (smp.sample_in < prev);
    assign rising = (state == RISE);

    // State register; the FSM only advances on valid samples, which is
    // handled in the next-state logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Direction only reverses on a strict compare, so plateaus of equal
    // samples keep the current slope. A reversal out of RISE means the
    // previous sample was the peak; out of FALL, the previous was the trough.
    always_comb begin
        state_next   = state;
        peak_event   = 1'b0;
        trough_event = 1'b0;
        if (smp.sample_valid) begin
            case (state)
                IDLE: state_next = ACQ;
                ACQ: begin
                    if (gt) begin
                        state_next = RISE;
                    end else if (lt) begin
                        state_next = FALL;
                    end
                end
                RISE: begin
                    if (lt) begin
                        peak_event = 1'b1;
                        state_next = FALL;
                    end
                end
                FALL: begin
                    if (gt) begin
                        trough_event = 1'b1;
                        state_next   = RISE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Capture peak/trough from the held previous sample and refresh the
    // amplitude against the opposite extreme. Early after reset the trough
    // can sit above the (zero) peak; the amplitude is clamped to 0 then.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev       <= '0;
            peak_val   <= '0;
            trough_val <= '0;
            amplitude  <= '0;
        end else if (smp.sample_valid) begin
            prev <= smp.sample_in;
            if (peak_event) begin
                peak_val  <= prev;
                amplitude <= (prev > trough_val) ? (prev - trough_val) : '0;
            end
            if (trough_event) begin
                trough_val <= prev;
                amplitude  <= (peak_val > prev) ? (peak_val - prev) : '0;
            end
        end
    end

    tri_period_meter #(
        .PER_W (PER_W)
    ) u_period_meter (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (smp.sample_valid),
        .peak_event   (peak_event),
        .period       (period),
        .meas_valid   (meas_valid),
        .locked       (locked)
    );

`ifdef TRI_WAVE_ANALYZER_STEP_CHECK_EN
    localparam logic [DATA_W-1:0] MAX_STEP_V = DATA_W'(MAX_STEP);

    logic [DATA_W-1:0] step_mag;

    assign step_mag = gt ? (smp.sample_in - prev) : (prev - smp.sample_in);

    // Sticky flag: in IDLE there is no meaningful previous sample yet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_err <= 1'b0;
        end else if (smp.sample_valid && (state != IDLE) && (step_mag > MAX_STEP_V)) begin
            step_err <= 1'b1;
        end
    end
`else
    // A step limit can never be negative, so this is a constant 0; writing it
    // against MAX_STEP keeps the parameter referenced when no checker exists.
    assign step_err = (MAX_STEP < 0);
`endif

endmodule : tri_wave_analyzer

// File: tb/tb_tri_wave_analyzer.sv
// ---------------------------------------------------------------------------
// tb_tri_wave_analyzer
// Directed bench for tri_wave_analyzer. Two instances share one stimulus
// stream: dut (default widths) and dut_sat (PER_W=4) for period saturation.
// Honours TRI_WAVE_ANALYZER_STEP_CHECK_EN for the step_err expectations.
// ---------------------------------------------------------------------------
module tb_tri_wave_analyzer;
    import tri_wave_pkg::*;

    logic clk;
    logic reset_n;

    int vectors;
    int miscompares;
    int seq_q[$];

    tri_wave_analyzer_if #(.DATA_W(8)) if_main ();
    tri_wave_analyzer_if #(.DATA_W(8)) if_sat ();

    logic [7:0]  peak_val, trough_val, amplitude;
    logic [15:0] period;
    logic        meas_valid, rising, locked, step_err;

    logic [7:0]  s_peak_val, s_trough_val, s_amplitude;
    logic [3:0]  s_period;
    logic        s_meas_valid, s_rising, s_locked, s_step_err;

`ifdef TRI_WAVE_ANALYZER_STEP_CHECK_EN
    localparam logic STEP_EXP = 1'b1;
`else
    localparam logic STEP_EXP = 1'b0;
`endif

    tri_wave_analyzer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .smp        (if_main.slave),
        .peak_val   (peak_val),
        .trough_val (trough_val),
        .amplitude  (amplitude),
        .period     (period),
        .meas_valid (meas_valid),
        .rising     (rising),
        .locked     (locked),
        .step_err   (step_err)
    );

    tri_wave_analyzer #(.DATA_W(8), .PER_W(4), .MAX_STEP(1)) dut_sat (
        .clk        (clk),
        .reset_n    (reset_n),
        .smp        (if_sat.slave),
        .peak_val   (s_peak_val),
        .trough_val (s_trough_val),
        .amplitude  (s_amplitude),
        .period     (s_period),
        .meas_valid (s_meas_valid),
        .rising     (s_rising),
        .locked     (s_locked),
        .step_err   (s_step_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample on the falling edge, then settle just past the
    // rising edge that consumes it.
    task automatic applyStimulus(input logic [7:0] s, input logic v);
        @(negedge clk);
        if_main.sample_in    = s;
        if_main.sample_valid = v;
        if_sat.sample_in     = s;
        if_sat.sample_valid  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Plays the queued samples as valid samples, then empties the queue.
    task automatic playSeq();
        foreach (seq_q[i]) applyStimulus(8'(seq_q[i]), 1'b1);
        seq_q.delete();
    endtask

    // Same, but every valid sample is followed by an idle cycle with junk data.
    task automatic playToggled();
        foreach (seq_q[i]) begin
            applyStimulus(8'(seq_q[i]), 1'b1);
            applyStimulus(8'hAA, 1'b0);
        end
        seq_q.delete();
    endtask

    task automatic doReset();
        @(negedge clk);
        if_main.sample_valid = 1'b0;
        if_sat.sample_valid  = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Linear sequence of directed steps with hand-computed expectations.
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        if_main.sample_in    = '0;
        if_main.sample_valid = 1'b0;
        if_sat.sample_in     = '0;
        if_sat.sample_valid  = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_peak",   32'(peak_val),   0);
        checkOutput("rst_trough", 32'(trough_val), 0);
        checkOutput("rst_amp",    32'(amplitude),  0);
        checkOutput("rst_period", 32'(period),     0);
        checkOutput("rst_meas",   32'(meas_valid), 0);
        checkOutput("rst_rising", 32'(rising),     0);
        checkOutput("rst_locked", 32'(locked),     0);
        checkOutput("rst_steperr", 32'(step_err),  0);
        reset_n = 1'b1;

        $display("[TB] basic triangle");
        seq_q = '{0, 1, 2, 3, 4};
        playSeq();
        checkOutput("t1_rising", 32'(rising), 1);
        seq_q = '{3};
        playSeq();
        checkOutput("t1_peak",     32'(peak_val),   4);
        checkOutput("t1_amp",      32'(amplitude),  4);
        checkOutput("t1_arm_meas", 32'(meas_valid), 0);
        seq_q = '{2, 1, 0, 1, 2, 3, 4, 3};
        playSeq();
        checkOutput("t1_meas",   32'(meas_valid), 1);
        checkOutput("t1_period", 32'(period),     8);
        checkOutput("t1_trough", 32'(trough_val), 0);
        checkOutput("t1_locked", 32'(locked),     0);
        seq_q = '{2};
        playSeq();
        checkOutput("t1_meas_pulse", 32'(meas_valid), 0);

        $display("[TB] lock and unlock");
        seq_q = '{1, 0, 1, 2, 3, 4, 3};
        playSeq();
        checkOutput("t2_meas",   32'(meas_valid), 1);
        checkOutput("t2_period", 32'(period),     8);
        checkOutput("t2_locked", 32'(locked),     1);
        seq_q = '{2, 1, 0, 1, 2, 3, 4, 5, 4};
        playSeq();
        checkOutput("t2_meas9",   32'(meas_valid), 1);
        checkOutput("t2_period9", 32'(period),     9);
        checkOutput("t2_unlock",  32'(locked),     0);
        checkOutput("t2_peak5",   32'(peak_val),   5);
        checkOutput("t2_amp5",    32'(amplitude),  5);

        $display("[TB] gapped stream");
        doReset();
        seq_q = '{0, 1, 2, 3, 4, 3};
        playToggled();
        checkOutput("t3_peak_held",   32'(peak_val), 4);
        checkOutput("t3_rising_held", 32'(rising),   0);
        seq_q = '{2, 1, 0, 1, 2, 3, 4};
        playToggled();
        applyStimulus(8'd3, 1'b1);
        checkOutput("t3_meas",   32'(meas_valid), 1);
        checkOutput("t3_period", 32'(period),     8);
        applyStimulus(8'hAA, 1'b0);
        checkOutput("t3_meas_gap",   32'(meas_valid), 0);
        checkOutput("t3_period_gap", 32'(period),     8);
        checkOutput("t3_peak_gap",   32'(peak_val),   4);

        $display("[TB] plateau");
        doReset();
        seq_q = '{0, 1, 2, 2, 2};
        playSeq();
        checkOutput("t4_plateau_rising", 32'(rising),   1);
        checkOutput("t4_plateau_peak",   32'(peak_val), 0);
        seq_q = '{3};
        playSeq();
        checkOutput("t4_rising3", 32'(rising), 1);
        seq_q = '{2};
        playSeq();
        checkOutput("t4_peak",   32'(peak_val),   3);
        checkOutput("t4_falling", 32'(rising),    0);
        checkOutput("t4_amp",    32'(amplitude),  3);
        checkOutput("t4_meas",   32'(meas_valid), 0);

        $display("[TB] trough above peak");
        doReset();
        seq_q = '{9, 8, 7, 8};
        playSeq();
        checkOutput("clamp_trough", 32'(trough_val), 7);
        checkOutput("clamp_amp",    32'(amplitude),  0);
        checkOutput("clamp_rising", 32'(rising),     1);

        $display("[TB] period saturation");
        doReset();
        seq_q = '{0, 1, 0};
        playSeq();
        for (int v = 1; v <= 21; v++) seq_q.push_back(v);
        playSeq();
        seq_q = '{20};
        playSeq();
        checkOutput("t5_meas",       32'(meas_valid),   1);
        checkOutput("t5_period",     32'(period),       22);
        checkOutput("t5_sat_meas",   32'(s_meas_valid), 1);
        checkOutput("t5_sat_period", 32'(s_period),     15);

        $display("[TB] async reset mid-fall");
        doReset();
        seq_q = '{0, 1, 2, 3, 2, 1};
        playSeq();
        checkOutput("t6_peak_pre", 32'(peak_val),  3);
        checkOutput("t6_amp_pre",  32'(amplitude), 3);
        checkOutput("t6_fall_pre", 32'(rising),    0);
        @(negedge clk);
        if_main.sample_valid = 1'b0;
        if_sat.sample_valid  = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_async_peak",   32'(peak_val),   0);
        checkOutput("t6_async_amp",    32'(amplitude),  0);
        checkOutput("t6_async_trough", 32'(trough_val), 0);
        checkOutput("t6_async_rising", 32'(rising),     0);
        @(negedge clk);
        reset_n = 1'b1;
        seq_q = '{0, 1, 2, 1};
        playSeq();
        checkOutput("t6_rearm_peak", 32'(peak_val),   2);
        checkOutput("t6_rearm_meas", 32'(meas_valid), 0);
        seq_q = '{0};
        playSeq();
        checkOutput("t6_rearm_meas2", 32'(meas_valid), 0);

        $display("[TB] step check");
        doReset();
        seq_q = '{0, 1, 5};
        playSeq();
        checkOutput("step_err_set", 32'(step_err), 32'(STEP_EXP));
        seq_q = '{6};
        playSeq();
        checkOutput("step_err_sticky", 32'(step_err), 32'(STEP_EXP));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_tri_wave_analyzer
